uart_tx_buffered: RTL

//   Buffered UART transmitter: 8N1 serial frames at a fixed baud, fed by a small byte FIFO.

---
 rtl/uart_tx_buffered.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: byte FIFO feeding an 8N1 UART transmitter at a fixed baud rate.
//   Optional feature macro: UART_PARITY_EN adds an even-parity bit between data and stop (8E1 frames).
//   Ports:
//     clk_i         system clock, all logic on the rising edge
//     reset_i       synchronous active-high reset; aborts any frame in flight and flushes the FIFO
//     tx_data_i     byte to queue
//     tx_valid_i    tx_data_i valid; pushed when tx_valid_i && tx_ready_o at a clock edge
//     tx_ready_o    FIFO not full (derived from the registered count only)
//     tx_busy_o     registered, high while a frame is on the line
//     fifo_count_o  registered count of queued bytes, excluding the byte in flight
//     uart_tx_o     registered serial line, idles high
module uart_tx_buffered #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD       = 9600,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic [7:0]                    tx_data_i,
    input  logic                          tx_valid_i,
    output logic                          tx_ready_o,
    output logic                          tx_busy_o,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          uart_tx_o
);
    localparam int CPB = CLK_FREQ / BAUD;
    localparam int TW  = $clog2(CPB);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int CW  = AW + 1;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]   count_q;
    logic [TW-1:0]   timer_q, timer_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
    logic            busy_q;
    logic            push, pop, bit_end, have_data;
    logic [7:0]      head;
`ifdef UART_PARITY_EN
    logic            par_q, par_d;
`endif

    assign head       = mem_q[rd_ptr_q];
    assign have_data  = count_q != '0;
    assign tx_ready_o = count_q != CW'(FIFO_DEPTH);
    assign push       = tx_valid_i && tx_ready_o;
    assign bit_end    = timer_q == TW'(CPB - 1);

    assign tx_busy_o    = busy_q;
    assign fifo_count_o = count_q;
    assign uart_tx_o    = tx_q;

    always_comb begin
        state_d = state_q;
        timer_d = bit_end ? '0 : timer_q + TW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = tx_q;
        pop     = 1'b0;
`ifdef UART_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (have_data) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = START;
`ifdef UART_PARITY_EN
                    par_d   = ^head;
`endif
                end
            end
            START: if (bit_end) begin
                state_d = DATA;
                bit_d   = '0;
                tx_d    = shift_q[0];
            end
            DATA: if (bit_end) begin
                if (bit_q == 3'd7) begin
`ifdef UART_PARITY_EN
                    state_d = PARITY;
                    tx_d    = par_q;
`else
                    state_d = STOP;
                    tx_d    = 1'b1;
`endif
                end else begin
                    bit_d   = bit_q + 3'd1;
                    shift_d = {1'b0, shift_q[7:1]};
                    tx_d    = shift_q[1];
                end
            end
`ifdef UART_PARITY_EN
            PARITY: if (bit_end) begin
                state_d = STOP;
                tx_d    = 1'b1;
            end
`endif
            STOP: if (bit_end) begin
                // Chain straight into the next start bit when a byte is waiting.
                if (have_data) begin
                    pop     = 1'b1;
                    shift_d = head;
                    tx_d    = 1'b0;
                    state_d = START;
`ifdef UART_PARITY_EN
                    par_d   = ^head;
`endif
                end else begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            bit_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
            busy_q   <= 1'b0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
`ifdef UART_PARITY_EN
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            bit_q    <= bit_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
            busy_q   <= state_d != IDLE;
            wr_ptr_q <= wr_ptr_q + AW'(push);
            rd_ptr_q <= rd_ptr_q + AW'(pop);
            count_q  <= count_q + CW'(push) - CW'(pop);
`ifdef UART_PARITY_EN
            par_q    <= par_d;
`endif
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= tx_data_i;
    end
endmodule
